// File: rtl/alu_sw_bus_pkg.sv
// Shared widths, bit positions and FSM states for the ALU switch/LED bus driver.
package alu_sw_bus_pkg;

  localparam int unsigned SW_W   = 16;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned OP_W   = 3;
  localparam int unsigned SH_W   = 3;
  localparam int unsigned FLAG_W = 4;
  localparam int unsigned CNT_W  = 4;

  // Switch word fields
  localparam int unsigned SA_BIT = 11;
  localparam int unsigned SB_BIT = 12;
  localparam int unsigned OP_LSB = 8;
  localparam int unsigned SH_LSB = 13;

  // LED word fields
  localparam int unsigned FLAG_LSB = 12;
  localparam int unsigned RSVD_BIT = 11;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_A = 3'd1,
    LOAD_B = 3'd2,
    EXEC   = 3'd3,
    RESP   = 3'd4
  } state_t;

endpackage

// File: rtl/alu_sw_word_pack.sv
// Combinational packer: {sh, Sb, Sa, op, data} -> 16-bit switch word.
module alu_sw_word_pack
  import alu_sw_bus_pkg::*;
(
  input  logic [SH_W-1:0]   sh,
  input  logic              sb,
  input  logic              sa,
  input  logic [OP_W-1:0]   op,
  input  logic [DATA_W-1:0] data,
  output logic [SW_W-1:0]   word
);

  // Place each field at its fixed bit position
  always_comb begin
    word                    = '0;
    word[DATA_W-1:0]        = data;
    word[OP_LSB +: OP_W]    = op;
    word[SA_BIT]            = sa;
    word[SB_BIT]            = sb;
    word[SH_LSB +: SH_W]    = sh;
  end

endmodule

// File: rtl/alu_sw_bus_driver.sv
// Bus initiator: plays one ALU command onto the switch word (load-A, load-B, execute)
// and returns the captured LED word over a valid/ready response.
module alu_sw_bus_driver
  import alu_sw_bus_pkg::*;
#(
  parameter int unsigned SETTLE = 1
) (
  input  logic              clk,
  input  logic              btnC,
  input  logic              ena,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [DATA_W-1:0] cmd_a,
  input  logic [DATA_W-1:0] cmd_b,
  input  logic [OP_W-1:0]   cmd_op,
  input  logic [SH_W-1:0]   cmd_sh,
  input  logic              cmd_skip_a,
  input  logic              cmd_skip_b,
  output logic [SW_W-1:0]   sw_out,
  input  logic [SW_W-1:0]   led_in,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_result,
  output logic [FLAG_W-1:0] rsp_flags,
  output logic              rsp_err,
  output logic              busy
);

  state_t              state_q, state_d;
  logic [SW_W-1:0]     sw_q, sw_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   b_q, b_d;
  logic [OP_W-1:0]     op_q, op_d;
  logic [SH_W-1:0]     sh_q, sh_d;
  logic                skip_b_q, skip_b_d;
  logic [DATA_W-1:0]   rsp_result_q, rsp_result_d;
  logic [FLAG_W-1:0]   rsp_flags_q, rsp_flags_d;
  logic                rsp_err_q, rsp_err_d;

  logic                idle;
  logic [DATA_W-1:0]   src_b;
  logic [OP_W-1:0]     src_op;
  logic [SH_W-1:0]     src_sh;
  logic [SW_W-1:0]     word_a, word_b, word_e;
  logic                led_err;

  assign idle = (state_q == IDLE);

  // On the accept edge the fields are not latched yet, so words come straight from cmd_*
  assign src_b  = idle ? cmd_b  : b_q;
  assign src_op = idle ? cmd_op : op_q;
  assign src_sh = idle ? cmd_sh : sh_q;

  alu_sw_word_pack u_pack_a (
    .sh(cmd_sh), .sb(1'b0), .sa(1'b1), .op(cmd_op), .data(cmd_a), .word(word_a)
  );

  alu_sw_word_pack u_pack_b (
    .sh(src_sh), .sb(1'b1), .sa(1'b0), .op(src_op), .data(src_b), .word(word_b)
  );

  alu_sw_word_pack u_pack_e (
    .sh(src_sh), .sb(1'b0), .sa(1'b0), .op(src_op), .data(DATA_W'(0)), .word(word_e)
  );

  // Error when the ALU echoes a different opcode or raises the reserved bit
  assign led_err = (led_in[OP_LSB +: OP_W] != op_q) | led_in[RSVD_BIT];

  // Next-state, next switch word and response capture
  always_comb begin
    state_d      = state_q;
    sw_d         = sw_q;
    cnt_d        = cnt_q;
    b_d          = b_q;
    op_d         = op_q;
    sh_d         = sh_q;
    skip_b_d     = skip_b_q;
    rsp_result_d = rsp_result_q;
    rsp_flags_d  = rsp_flags_q;
    rsp_err_d    = rsp_err_q;

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          b_d      = cmd_b;
          op_d     = cmd_op;
          sh_d     = cmd_sh;
          skip_b_d = cmd_skip_b;
          cnt_d    = '0;
          if (!cmd_skip_a) begin
            state_d = LOAD_A;
            sw_d    = word_a;
          end else if (!cmd_skip_b) begin
            state_d = LOAD_B;
            sw_d    = word_b;
          end else begin
            state_d = EXEC;
            sw_d    = word_e;
          end
        end
      end
      LOAD_A: begin
        if (ena) begin
          if (!skip_b_q) begin
            state_d = LOAD_B;
            sw_d    = word_b;
          end else begin
            state_d = EXEC;
            sw_d    = word_e;
          end
        end
      end
      LOAD_B: begin
        if (ena) begin
          state_d = EXEC;
          sw_d    = word_e;
        end
      end
      EXEC: begin
        if (ena) begin
          if (cnt_q == CNT_W'(SETTLE)) begin
            state_d      = RESP;
            sw_d         = '0;
            rsp_result_d = led_in[DATA_W-1:0];
            rsp_flags_d  = led_in[FLAG_LSB +: FLAG_W];
            rsp_err_d    = led_err;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        sw_d    = '0;
      end
    endcase
  end

  // State and datapath registers; reset aborts any command and clears the bus
  always_ff @(posedge clk or posedge btnC) begin
    if (btnC) begin
      state_q      <= IDLE;
      sw_q         <= '0;
      cnt_q        <= '0;
      b_q          <= '0;
      op_q         <= '0;
      sh_q         <= '0;
      skip_b_q     <= 1'b0;
      rsp_result_q <= '0;
      rsp_flags_q  <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      sw_q         <= sw_d;
      cnt_q        <= cnt_d;
      b_q          <= b_d;
      op_q         <= op_d;
      sh_q         <= sh_d;
      skip_b_q     <= skip_b_d;
      rsp_result_q <= rsp_result_d;
      rsp_flags_q  <= rsp_flags_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  assign cmd_ready  = idle & ~btnC;
  assign busy       = ~idle;
  assign rsp_valid  = (state_q == RESP);
  assign sw_out     = sw_q;
  assign rsp_result = rsp_result_q;
  assign rsp_flags  = rsp_flags_q;
  assign rsp_err    = rsp_err_q;

endmodule

// File: tb/tb_alu_sw_bus_driver.sv
// Directed bench for alu_sw_bus_driver; the bench plays the ALU by driving led_in.
module tb_alu_sw_bus_driver;

  logic        clk = 1'b0;
  logic        btnC;
  logic        ena;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_a, cmd_b;
  logic [2:0]  cmd_op, cmd_sh;
  logic        cmd_skip_a, cmd_skip_b;
  logic [15:0] sw_out;
  logic [15:0] led_in;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [7:0]  rsp_result;
  logic [3:0]  rsp_flags;
  logic        rsp_err;
  logic        busy;

  int n_checks = 0;
  int n_pass   = 0;

  alu_sw_bus_driver #(.SETTLE(1)) dut (
    .clk(clk), .btnC(btnC), .ena(ena),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op), .cmd_sh(cmd_sh),
    .cmd_skip_a(cmd_skip_a), .cmd_skip_b(cmd_skip_b),
    .sw_out(sw_out), .led_in(led_in),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_flags(rsp_flags), .rsp_err(rsp_err),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Offer a command and let it be accepted on the next edge; returns just after that edge
  task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                       input logic [2:0] sh, input logic ska, input logic skb);
    cmd_a = a; cmd_b = b; cmd_op = op; cmd_sh = sh;
    cmd_skip_a = ska; cmd_skip_b = skb;
    cmd_valid = 1'b1;
    chk("ready_before_accept", 16'(cmd_ready), 16'h1);
    step();
    cmd_valid = 1'b0;
  endtask

  initial begin
    btnC = 1'b1; ena = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b1;
    cmd_a = '0; cmd_b = '0; cmd_op = '0; cmd_sh = '0;
    cmd_skip_a = 1'b0; cmd_skip_b = 1'b0; led_in = '0;

    // Reset state
    step(); step();
    chk("rst_sw", sw_out, 16'h0000);
    chk("rst_ready", 16'(cmd_ready), 16'h0);
    chk("rst_valid", 16'(rsp_valid), 16'h0);
    chk("rst_busy", 16'(busy), 16'h0);
    chk("rst_result", 16'(rsp_result), 16'h0);
    btnC = 1'b0;
    step();
    chk("post_rst_ready", 16'(cmd_ready), 16'h1);

    // 1: full command
    led_in = 16'h5207;
    issue(8'h3C, 8'h05, 3'b010, 3'd1, 1'b0, 1'b0);
    chk("t1_sw_load_a", sw_out, 16'h2A3C);
    chk("t1_busy", 16'(busy), 16'h1);
    chk("t1_ready_busy", 16'(cmd_ready), 16'h0);
    step(); chk("t1_sw_load_b", sw_out, 16'h3205);
    step(); chk("t1_sw_exec", sw_out, 16'h2200);
    chk("t1_valid_n2", 16'(rsp_valid), 16'h0);
    step(); chk("t1_valid_n3", 16'(rsp_valid), 16'h0);
    step(); chk("t1_valid_n4", 16'(rsp_valid), 16'h1);
    chk("t1_result", 16'(rsp_result), 16'h0007);
    chk("t1_flags", 16'(rsp_flags), 16'h0005);
    chk("t1_err", 16'(rsp_err), 16'h0);
    chk("t1_sw_resp", sw_out, 16'h0000);
    step(); chk("t1_back_idle_valid", 16'(rsp_valid), 16'h0);
    chk("t1_back_idle_ready", 16'(cmd_ready), 16'h1);

    // 2: both loads skipped
    led_in = 16'hA199;
    issue(8'h11, 8'h22, 3'b001, 3'd2, 1'b1, 1'b1);
    chk("t2_sw_exec", sw_out, 16'h4100);
    step(); chk("t2_valid_n1", 16'(rsp_valid), 16'h0);
    step(); chk("t2_valid_n2", 16'(rsp_valid), 16'h1);
    chk("t2_result", 16'(rsp_result), 16'h0099);
    chk("t2_flags", 16'(rsp_flags), 16'h000A);
    chk("t2_err", 16'(rsp_err), 16'h0);
    step();

    // 3: ena low for three cycles during LOAD_B
    led_in = 16'h5207;
    issue(8'h3C, 8'h05, 3'b010, 3'd1, 1'b0, 1'b0);
    chk("t3_sw_load_a", sw_out, 16'h2A3C);
    step(); chk("t3_sw_load_b", sw_out, 16'h3205);
    ena = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(); chk("t3_sw_hold", sw_out, 16'h3205);
    end
    ena = 1'b1;
    step(); chk("t3_sw_exec", sw_out, 16'h2200);
    step(); chk("t3_valid_n6", 16'(rsp_valid), 16'h0);
    step(); chk("t3_valid_n7", 16'(rsp_valid), 16'h1);
    chk("t3_result", 16'(rsp_result), 16'h0007);
    step();

    // 4a: op echo mismatch
    led_in = 16'h5307;
    issue(8'h00, 8'h00, 3'b010, 3'd0, 1'b1, 1'b1);
    step(); step();
    chk("t4a_valid", 16'(rsp_valid), 16'h1);
    chk("t4a_err", 16'(rsp_err), 16'h1);
    step();

    // 4b: reserved bit set
    led_in = 16'h5A07;
    issue(8'h00, 8'h00, 3'b010, 3'd0, 1'b1, 1'b1);
    step(); step();
    chk("t4b_valid", 16'(rsp_valid), 16'h1);
    chk("t4b_err", 16'(rsp_err), 16'h1);
    chk("t4b_result", 16'(rsp_result), 16'h0007);
    step();

    // 5: response backpressure with a pending command
    led_in = 16'h3342;
    rsp_ready = 1'b0;
    issue(8'h00, 8'h00, 3'b011, 3'd0, 1'b1, 1'b1);
    step(); step();
    led_in = 16'hFFFF;
    cmd_op = 3'b100; cmd_sh = 3'd0; cmd_skip_a = 1'b1; cmd_skip_b = 1'b1;
    cmd_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("t5_valid_hold", 16'(rsp_valid), 16'h1);
      chk("t5_result_hold", 16'(rsp_result), 16'h0042);
      chk("t5_flags_hold", 16'(rsp_flags), 16'h0003);
      chk("t5_err_hold", 16'(rsp_err), 16'h0);
      chk("t5_ready_low", 16'(cmd_ready), 16'h0);
      step();
    end
    rsp_ready = 1'b1;
    step();
    chk("t5_after_hs_valid", 16'(rsp_valid), 16'h0);
    chk("t5_after_hs_ready", 16'(cmd_ready), 16'h1);
    chk("t5_not_yet_busy", 16'(busy), 16'h0);
    led_in = 16'h1410;
    step();
    cmd_valid = 1'b0;
    chk("t5_next_accepted", 16'(busy), 16'h1);
    chk("t5_next_sw", sw_out, 16'h0400);
    step(); step();
    chk("t5_next_valid", 16'(rsp_valid), 16'h1);
    chk("t5_next_result", 16'(rsp_result), 16'h0010);
    step();

    // 6: reset pulse during LOAD_B
    led_in = 16'h5207;
    issue(8'h3C, 8'h05, 3'b010, 3'd1, 1'b0, 1'b0);
    step(); chk("t6_sw_load_b", sw_out, 16'h3205);
    btnC = 1'b1;
    #1;
    chk("t6_sw_async_clear", sw_out, 16'h0000);
    chk("t6_ready_in_rst", 16'(cmd_ready), 16'h0);
    chk("t6_busy_in_rst", 16'(busy), 16'h0);
    step();
    btnC = 1'b0;
    step();
    chk("t6_ready_after", 16'(cmd_ready), 16'h1);
    for (int i = 0; i < 6; i++) begin
      chk("t6_no_rsp", 16'(rsp_valid), 16'h0);
      step();
    end
    chk("t6_sw_idle", sw_out, 16'h0000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
